// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// spi_cmd_pkg : FSM state encoding and default opcodes for spi_cmd_slave
// Rev 1.0
// ============================================================================
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RTURN  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

  localparam logic [7:0] CMD_WRITE_DEF = 8'hAA;
  localparam logic [7:0] CMD_READ_DEF  = 8'h55;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_slave_if.sv
`default_nettype none
// ============================================================================
// spi_cmd_slave_if : register-bus side of spi_cmd_slave (write/read strobes)
// Rev 1.0
// ============================================================================
interface spi_cmd_slave_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);

  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_address_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_address_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              err_o;

  // master: the SPI slave issuing bus requests; slave: the register file
  modport master (
    output wr_en_o, wr_address_o, wr_data_o,
    output rd_en_o, rd_address_o, err_o,
    input  rd_data_i
  );

  modport slave (
    input  wr_en_o, wr_address_o, wr_data_o,
    input  rd_en_o, rd_address_o, err_o,
    output rd_data_i
  );

endinterface
`default_nettype wire

// File: rtl/spi_shreg.sv
`default_nettype none
// ============================================================================
// spi_shreg : MSB-first shift register with parallel load and sync clear
// Rev 1.0
// ============================================================================
module spi_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (WIDTH > 1) begin : g_wide
      assign w_shifted = {shreg_q[WIDTH-2:0], ser_i};
    end else begin : g_bit
      assign w_shifted = ser_i;
    end
  endgenerate

  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = '0;
    end else if (load_i) begin
      shreg_d = load_data_i;
    end else if (shift_i) begin
      shreg_d = w_shifted;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q_o = shreg_q;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_slave.sv
`default_nettype none
// ============================================================================
// spi_cmd_slave : SPI command/address/data frame decoder driving a register bus
// Rev 1.0
// ============================================================================
module spi_cmd_slave
  import spi_cmd_pkg::*;
#(
  parameter int              CMD_W     = 8,
  parameter int              ADDR_W    = 24,
  parameter int              DATA_W    = 32,
  parameter logic [CMD_W-1:0] CMD_WRITE = CMD_W'(CMD_WRITE_DEF),
  parameter logic [CMD_W-1:0] CMD_READ  = CMD_W'(CMD_READ_DEF),
  parameter int              BURST_EN  = 1
) (
  input  logic            spi_sck_i,
  input  logic            arst_i,
  input  logic            spi_cs_i,
  input  logic            spi_copi_i,
  output logic            spi_cipo_o,
  spi_cmd_slave_if.master bus_if
);

  localparam int RX_W  = max3(CMD_W, ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(RX_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_wr_q, is_wr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic              w_rx_shift;
  logic              w_tx_load;
  logic              w_tx_shift;
  logic              w_clr;
  logic [RX_W-1:0]   w_rx_q;
  logic [RX_W-1:0]   w_rx_word;
  logic [DATA_W-1:0] w_tx_q;
  logic              w_unused;

  spi_shreg #(.WIDTH(RX_W)) u_rx_shreg (
    .clk_i       (spi_sck_i),
    .rst_i       (arst_i),
    .clr_i       (w_clr),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (w_rx_shift),
    .ser_i       (spi_copi_i),
    .q_o         (w_rx_q)
  );

  spi_shreg #(.WIDTH(DATA_W)) u_tx_shreg (
    .clk_i       (spi_sck_i),
    .rst_i       (arst_i),
    .clr_i       (w_clr),
    .load_i      (w_tx_load),
    .load_data_i (bus_if.rd_data_i),
    .shift_i     (w_tx_shift),
    .ser_i       (1'b0),
    .q_o         (w_tx_q)
  );

  // The field completes on the edge that samples its last bit, so decode
  // the word as it will be after this edge's shift.
  assign w_rx_word = {w_rx_q[RX_W-2:0], spi_copi_i};
  assign w_unused  = ^{w_rx_q[RX_W-1], w_tx_q[DATA_W-2:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    is_wr_d    = is_wr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    w_rx_shift = 1'b0;
    w_tx_load  = 1'b0;
    w_tx_shift = 1'b0;
    w_clr      = 1'b0;

    if (!spi_cs_i) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      w_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_CMD: begin
          w_rx_shift = 1'b1;
          if (cnt_q == CMD_LAST) begin
            cnt_d = '0;
            if (w_rx_word[CMD_W-1:0] == CMD_WRITE || w_rx_word[CMD_W-1:0] == CMD_READ) begin
              state_d = ST_ADDR;
              is_wr_d = (w_rx_word[CMD_W-1:0] == CMD_WRITE);
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ADDR: begin
          w_rx_shift = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            addr_d  = w_rx_word[ADDR_W-1:0];
            state_d = is_wr_q ? ST_WDATA : ST_RTURN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          w_rx_shift = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = w_rx_word[DATA_W-1:0];
            if (BURST_EN != 0) begin
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RTURN: begin
          w_tx_load = 1'b1;
          state_d   = ST_RDATA;
        end
        ST_RDATA: begin
          w_tx_shift = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (BURST_EN != 0) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_RTURN;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge spi_sck_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_CMD;
      cnt_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign bus_if.wr_en_o      = wr_en_q;
  assign bus_if.wr_address_o = wr_addr_q;
  assign bus_if.wr_data_o    = wr_data_q;
  assign bus_if.rd_en_o      = (state_q == ST_RTURN);
  assign bus_if.rd_address_o = addr_q;
  assign bus_if.err_o        = err_q;
  assign spi_cipo_o          = (state_q == ST_RDATA) ? w_tx_q[DATA_W-1] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_cmd_slave : frame-level reference model check of spi_cmd_slave
// Rev 1.0
// ============================================================================
module tb_spi_cmd_slave;

  localparam logic [7:0] OP_WR = 8'hAA;
  localparam logic [7:0] OP_RD = 8'h55;

  typedef struct packed {
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [23:0] rd_addr;
    logic        err;
    logic        cipo;
  } exp_t;

  logic        sck;
  logic        arst;
  logic        cs;
  logic        copi;
  logic        cipo;
  logic [31:0] rd_key;

  int n_vec;
  int n_err;

  logic [7:0]  fr_op;
  logic [23:0] fr_addr;
  logic [31:0] fr_wdata[$];
  bit          fr_bits[$];

  spi_cmd_slave_if #(.ADDR_W(24), .DATA_W(32)) bus_if ();

  spi_cmd_slave #(
    .CMD_W    (8),
    .ADDR_W   (24),
    .DATA_W   (32),
    .CMD_WRITE(8'hAA),
    .CMD_READ (8'h55),
    .BURST_EN (1)
  ) u_dut (
    .spi_sck_i  (sck),
    .arst_i     (arst),
    .spi_cs_i   (cs),
    .spi_copi_i (copi),
    .spi_cipo_o (cipo),
    .bus_if     (bus_if)
  );

  // Register-file stand-in: read data is a keyed function of the address.
  assign bus_if.rd_data_i = {8'h00, bus_if.rd_address_o} ^ rd_key;

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs in the cycle after the rising edge that samples frame bit e.
  function automatic exp_t model_at(input int e);
    exp_t        x;
    int          j;
    int          k;
    int          r;
    logic [23:0] a;
    logic [31:0] d;
    x = '0;
    if (fr_op == OP_WR) begin
      if (e >= 32 && ((e - 31) % 32) == 0) begin
        j         = (e - 32) / 32;
        x.wr_en   = 1'b1;
        x.wr_addr = fr_addr + 24'(j);
        x.wr_data = fr_wdata[j];
      end
    end else if (fr_op == OP_RD) begin
      if (e >= 31) begin
        k = e - 31;
        j = k / 33;
        r = k % 33;
        a = fr_addr + 24'(j);
        if (r == 0) begin
          x.rd_en   = 1'b1;
          x.rd_addr = a;
        end else begin
          d      = {8'h00, a} ^ rd_key;
          x.cipo = d[32 - r];
        end
      end
    end else if (e == 7) begin
      x.err = 1'b1;
    end
    return x;
  endfunction

  task automatic check_cycle(input int e);
    exp_t x;
    x = model_at(e);
    check_value($sformatf("wr_en@%0d", e), 64'(bus_if.wr_en_o), 64'(x.wr_en));
    check_value($sformatf("rd_en@%0d", e), 64'(bus_if.rd_en_o), 64'(x.rd_en));
    check_value($sformatf("err@%0d", e),   64'(bus_if.err_o),   64'(x.err));
    check_value($sformatf("cipo@%0d", e),  64'(cipo),           64'(x.cipo));
    if (x.wr_en) begin
      check_value($sformatf("wr_addr@%0d", e), 64'(bus_if.wr_address_o), 64'(x.wr_addr));
      check_value($sformatf("wr_data@%0d", e), 64'(bus_if.wr_data_o),    64'(x.wr_data));
    end
    if (x.rd_en) begin
      check_value($sformatf("rd_addr@%0d", e), 64'(bus_if.rd_address_o), 64'(x.rd_addr));
    end
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, ".wr_en"}, 64'(bus_if.wr_en_o), 64'd0);
    check_value({tag, ".rd_en"}, 64'(bus_if.rd_en_o), 64'd0);
    check_value({tag, ".err"},   64'(bus_if.err_o),   64'd0);
    check_value({tag, ".cipo"},  64'(cipo),           64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_idle(tag);
    check_value({tag, ".wr_addr"}, 64'(bus_if.wr_address_o), 64'd0);
    check_value({tag, ".wr_data"}, 64'(bus_if.wr_data_o),    64'd0);
    check_value({tag, ".rd_addr"}, 64'(bus_if.rd_address_o), 64'd0);
  endtask

  task automatic setup_frame(input logic [7:0] op, input logic [23:0] addr,
                             input int n_words, input int cut);
    logic [31:0] w;
    fr_op   = op;
    fr_addr = addr;
    fr_bits.delete();
    for (int i = 7; i >= 0; i--) fr_bits.push_back(op[i]);
    if (op == OP_WR || op == OP_RD) begin
      for (int i = 23; i >= 0; i--) fr_bits.push_back(addr[i]);
    end
    if (op == OP_WR) begin
      for (int n = 0; n < n_words; n++) begin
        w = fr_wdata[n];
        for (int i = 31; i >= 0; i--) fr_bits.push_back(w[i]);
      end
    end else if (op == OP_RD) begin
      for (int i = 0; i < 33 * n_words; i++) fr_bits.push_back(1'($urandom_range(0, 1)));
    end else begin
      for (int i = 0; i < 56; i++) fr_bits.push_back(1'($urandom_range(0, 1)));
    end
    if (cut > 0) begin
      while (fr_bits.size() > cut) void'(fr_bits.pop_back());
    end
  endtask

  task automatic run_frame();
    int nb;
    nb = fr_bits.size();
    for (int e = 0; e < nb; e++) begin
      @(negedge sck);
      if (e == 0) check_idle("pre");
      else        check_cycle(e - 1);
      cs   = 1'b1;
      copi = fr_bits[e];
    end
    @(negedge sck);
    check_cycle(nb - 1);
    cs   = 1'b0;
    copi = 1'b0;
    @(negedge sck);
    check_idle("post");
  endtask

  task automatic run_reset_abort();
    for (int e = 0; e < 16; e++) begin
      @(negedge sck);
      if (e == 0) check_idle("pre");
      else        check_cycle(e - 1);
      cs   = 1'b1;
      copi = fr_bits[e];
    end
    @(negedge sck);
    check_cycle(15);
    #1 arst = 1'b1;
    #1 check_all_zero("arst");
    @(negedge sck);
    check_all_zero("arst_hold");
    cs   = 1'b0;
    copi = 1'b0;
    arst = 1'b0;
    @(negedge sck);
    check_idle("arst_rel");
  endtask

  task automatic write_frame(input logic [23:0] addr, input int n, input int cut);
    fr_wdata.delete();
    for (int i = 0; i < n; i++) fr_wdata.push_back($urandom);
    setup_frame(OP_WR, addr, n, cut);
    run_frame();
  endtask

  task automatic run_random_frame();
    int          kind;
    int          n;
    int          cut;
    logic [23:0] a;
    logic [7:0]  op;
    kind   = $urandom_range(0, 2);
    n      = $urandom_range(1, 3);
    cut    = 0;
    a      = 24'($urandom);
    rd_key = $urandom;
    if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
    if ($urandom_range(0, 4) == 0) cut = $urandom_range(1, 32 + 32 * n);
    case (kind)
      0: write_frame(a, n, cut);
      1: begin
        setup_frame(OP_RD, a, n, cut);
        run_frame();
      end
      default: begin
        op = 8'($urandom);
        while (op == OP_WR || op == OP_RD) op = 8'($urandom);
        setup_frame(op, a, 0, cut);
        run_frame();
      end
    endcase
    repeat ($urandom_range(0, 2)) begin
      @(negedge sck);
      check_idle("gap");
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    arst   = 1'b1;
    cs     = 1'b0;
    copi   = 1'b0;
    rd_key = 32'h0;
    repeat (2) @(negedge sck);
    check_all_zero("reset");
    arst = 1'b0;
    @(negedge sck);
    check_idle("reset_rel");

    // Single write
    fr_wdata.delete();
    fr_wdata.push_back(32'hDEADBEEF);
    setup_frame(OP_WR, 24'h000010, 1, 0);
    run_frame();

    // Burst write across the address wrap
    fr_wdata.delete();
    fr_wdata.push_back(32'h11111111);
    fr_wdata.push_back(32'h22222222);
    setup_frame(OP_WR, 24'hFFFFFF, 2, 0);
    run_frame();

    // Single read returning CAFEF00D at address 000020
    rd_key = 32'hCAFEF00D ^ 32'h00000020;
    setup_frame(OP_RD, 24'h000020, 1, 0);
    run_frame();

    // Burst read
    rd_key = $urandom;
    setup_frame(OP_RD, 24'hFFFFFE, 3, 0);
    run_frame();

    // Unknown opcode
    setup_frame(8'h3C, 24'h0, 0, 0);
    run_frame();

    // Chip select dropped after 20 data bits, then a clean frame
    write_frame(24'h000123, 1, 32 + 20);
    write_frame(24'h000124, 1, 0);

    // Reset during address phase, then a clean frame
    fr_wdata.delete();
    fr_wdata.push_back(32'h01234567);
    setup_frame(OP_WR, 24'hABCDEF, 1, 0);
    run_reset_abort();
    write_frame(24'h000040, 1, 0);

    for (int f = 0; f < 40; f++) run_random_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
